// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for dmem_arbiter: request handshake plus response pulse.
// The master modport is the requester; the slave modport is the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Requests are serialised through IDLE -> ACCESS -> RESP. One access per 3 cycles.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     req0,
  dmem_arbiter_if.slave     req1,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_we_q;
  logic              r_id_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_wdata_q;
  logic [DATA_W-1:0] r_rdata_q;

  logic              w_grant1;
  logic              w_ready0;
  logic              w_ready1;
  logic              w_rvalid0;
  logic              w_rvalid1;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_hs0;
  logic              w_hs1;
  logic              w_hs;

`ifdef DMEM_ARB_RR_EN
  logic              r_last_grant;

  // Round-robin: on a tie, grant the port that did not win last time.
  assign w_grant1 = req1.valid & (~req0.valid | ~r_last_grant);

  // Remember the winner of every handshake; reset favours port 0 first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_hs) begin
      r_last_grant <= w_hs1;
    end
  end
`else
  // Fixed priority: port 1 wins only when port 0 is idle.
  assign w_grant1 = req1.valid & ~req0.valid;
`endif

  assign w_hs0 = req0.valid & w_ready0;
  assign w_hs1 = req1.valid & w_ready1;
  assign w_hs  = w_hs0 | w_hs1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: ACCESS and RESP each last exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_hs) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; ready is gated by rst_n so it stays low while reset is held.
  always_comb begin
    w_ready0    = 1'b0;
    w_ready1    = 1'b0;
    w_rvalid0   = 1'b0;
    w_rvalid1   = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready0 = rst_n & req0.valid & ~w_grant1;
        w_ready1 = rst_n & w_grant1;
      end
      S_ACCESS: begin
        w_mem_read  = ~r_we_q;
        w_mem_write = r_we_q;
      end
      S_RESP: begin
        w_rvalid0 = ~r_id_q;
        w_rvalid1 = r_id_q;
      end
      default: begin
        w_ready0 = 1'b0;
      end
    endcase
  end

  // Latch the winning request on handshake; capture read data at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_q    <= 1'b0;
      r_id_q    <= 1'b0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      r_rdata_q <= '0;
    end else begin
      if (r_state == S_IDLE && w_hs) begin
        r_id_q <= w_hs1;
        if (w_hs1) begin
          r_we_q    <= req1.we;
          r_addr_q  <= req1.addr;
          r_wdata_q <= req1.wdata;
        end else begin
          r_we_q    <= req0.we;
          r_addr_q  <= req0.addr;
          r_wdata_q <= req0.wdata;
        end
      end
      if (r_state == S_ACCESS) begin
        r_rdata_q <= r_we_q ? '0 : i_mem_read_data;
      end
    end
  end

  assign req0.ready  = w_ready0;
  assign req1.ready  = w_ready1;
  assign req0.rvalid = w_rvalid0;
  assign req1.rvalid = w_rvalid1;
  assign req0.rdata  = r_rdata_q;
  assign req1.rdata  = r_rdata_q;

  assign o_mem_addr       = r_addr_q;
  assign o_mem_write_data = r_wdata_q;
  assign o_mem_read       = w_mem_read;
  assign o_mem_write      = w_mem_write;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [4096] = '{default: 32'h0};

  int total = 0;
  int bad   = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) req0_if ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) req1_if ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req0             (req0_if),
    .req1             (req1_if),
    .o_mem_addr       (mem_addr),
    .o_mem_write_data (mem_wdata),
    .o_mem_read       (mem_read),
    .o_mem_write      (mem_write),
    .i_mem_read_data  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16 KiB word memory, combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[13:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[13:2]] <= mem_wdata;
  end

  typedef struct {
    bit          v0;
    bit          we0;
    logic [31:0] a0;
    logic [31:0] d0;
    bit          v1;
    bit          we1;
    logic [31:0] a1;
    logic [31:0] d1;
    int          g_rr;
    int          g_fp;
    logic [31:0] r_rr;
    logic [31:0] r_fp;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int p, input bit v, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_if.valid = v; req0_if.we = we; req0_if.addr = a; req0_if.wdata = d;
    end else begin
      req1_if.valid = v; req1_if.we = we; req1_if.addr = a; req1_if.wdata = d;
    end
  endtask

  // One transaction from IDLE: grant, single ACCESS cycle, then RESP pulse.
  task automatic run_vec(input int i);
    int          g;
    logic [31:0] er;
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    g  = RR ? vecs[i].g_rr : vecs[i].g_fp;
    er = RR ? vecs[i].r_rr : vecs[i].r_fp;
    we = (g == 0) ? vecs[i].we0 : vecs[i].we1;
    a  = (g == 0) ? vecs[i].a0  : vecs[i].a1;
    d  = (g == 0) ? vecs[i].d0  : vecs[i].d1;
    @(negedge clk);
    drive(0, vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0);
    drive(1, vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
    #1;
    chk($sformatf("v%0d_ready0", i), 32'(req0_if.ready), 32'(g == 0));
    chk($sformatf("v%0d_ready1", i), 32'(req1_if.ready), 32'(g == 1));
    @(negedge clk);
    if (g == 0) req0_if.valid = 1'b0; else req1_if.valid = 1'b0;
    #1;
    chk($sformatf("v%0d_mem_read", i),  32'(mem_read),  32'(!we));
    chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(we));
    chk($sformatf("v%0d_mem_addr", i),  mem_addr, a);
    chk($sformatf("v%0d_mem_wdata", i), mem_wdata, d);
    chk($sformatf("v%0d_busy_ready", i), 32'({req0_if.ready, req1_if.ready}), 32'h0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_rvalid0", i), 32'(req0_if.rvalid), 32'(g == 0));
    chk($sformatf("v%0d_rvalid1", i), 32'(req1_if.rvalid), 32'(g == 1));
    chk($sformatf("v%0d_rdata", i), (g == 0) ? req0_if.rdata : req1_if.rdata, er);
    req0_if.valid = 1'b0;
    req1_if.valid = 1'b0;
  endtask

  initial begin
    int exp_g [4];

    //          v0   we0  a0          d0            v1   we1  a1          d1            grr gfp rrr           rfp
    vecs[0]  = '{1'b1, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 1'b0, 32'h0,    32'h0,        0, 0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h20,   32'h55AA55AA, 1, 1, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h20,   32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        0, 0, 32'h55AA55AA, 32'h55AA55AA};
    vecs[4]  = '{1'b1, 1'b0, 32'h4010, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b1, 1'b0, 32'h20,   32'h0,        1, 0, 32'h55AA55AA, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 1'b1, 32'h0,    32'h11,       1'b1, 1'b1, 32'h4,    32'h22,       0, 0, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h4,    32'h22,       1, 1, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h4,    32'h0,        0, 0, 32'h11,       32'h11};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h4,    32'h0,        1, 0, 32'h22,       32'h11};
    vecs[10] = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h13,   32'h0,        1, 1, 32'hDEADBEEF, 32'hDEADBEEF};

    // Reset held with both requesters valid: nothing may be granted or issued.
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst%0d_ready", c),  32'({req0_if.ready, req1_if.ready}), 32'h0);
      chk($sformatf("rst%0d_rvalid", c), 32'({req0_if.rvalid, req1_if.rvalid}), 32'h0);
      chk($sformatf("rst%0d_mem_rw", c), 32'({mem_read, mem_write}), 32'h0);
    end
    chk("rst_rdata", req0_if.rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready0", 32'(req0_if.ready), 32'h1);
    chk("rel_ready1", 32'(req1_if.ready), 32'h0);
    @(negedge clk);
    req0_if.valid = 1'b0;
    req1_if.valid = 1'b0;
    #1;
    chk("rel_mem_read", 32'(mem_read), 32'h1);
    @(negedge clk);
    #1;
    chk("rel_rvalid0", 32'(req0_if.rvalid), 32'h1);
    chk("rel_rdata0", req0_if.rdata, 32'h0);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Continuous tie: both requesters keep valid high for four grants.
    exp_g[0] = 0;
    exp_g[1] = RR ? 1 : 0;
    exp_g[2] = 0;
    exp_g[3] = RR ? 1 : 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
      end
      #1;
      chk($sformatf("tie%0d_ready0", c), 32'(req0_if.ready), 32'((c % 3 == 0) && exp_g[c / 3] == 0));
      chk($sformatf("tie%0d_ready1", c), 32'(req1_if.ready), 32'((c % 3 == 0) && exp_g[c / 3] == 1));
      chk($sformatf("tie%0d_rvalid0", c), 32'(req0_if.rvalid), 32'((c % 3 == 2) && exp_g[c / 3] == 0));
      chk($sformatf("tie%0d_rvalid1", c), 32'(req1_if.rvalid), 32'((c % 3 == 2) && exp_g[c / 3] == 1));
      if (c % 3 == 2) begin
        chk($sformatf("tie%0d_rdata", c), (exp_g[c / 3] == 0) ? req0_if.rdata : req1_if.rdata,
            (exp_g[c / 3] == 0) ? 32'h11 : 32'h22);
      end
    end
    req0_if.valid = 1'b0;
    req1_if.valid = 1'b0;

    // Port 1 raises valid while busy and withdraws before IDLE: no access follows.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk("wd_ready0", 32'(req0_if.ready), 32'h1);
    @(negedge clk);
    req0_if.valid = 1'b0;
    drive(1, 1'b1, 1'b1, 32'h40, 32'h99);
    #1;
    chk("wd_access_ready1", 32'(req1_if.ready), 32'h0);
    @(negedge clk);
    #1;
    chk("wd_rvalid0", 32'(req0_if.rvalid), 32'h1);
    chk("wd_rdata0", req0_if.rdata, 32'hDEADBEEF);
    chk("wd_resp_ready1", 32'(req1_if.ready), 32'h0);
    req1_if.valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wd%0d_mem_rw", c), 32'({mem_read, mem_write}), 32'h0);
    end
    chk("wd_mem_untouched", mem[16], 32'h0);

    // Reset during a write ACCESS: the write must not commit and no response follows.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h30, 32'h1234);
    #1;
    chk("ra_ready0", 32'(req0_if.ready), 32'h1);
    @(negedge clk);
    #1;
    chk("ra_mem_write_before", 32'(mem_write), 32'h1);
    req0_if.valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ra_mem_write_drop", 32'(mem_write), 32'h0);
    chk("ra_mem_read_drop", 32'(mem_read), 32'h0);
    @(negedge clk);
    #1;
    chk("ra_rvalid0", 32'(req0_if.rvalid), 32'h0);
    chk("ra_mem_unchanged", mem[12], 32'h0);
    rst_n = 1'b1;
    drive(1, 1'b1, 1'b0, 32'h30, 32'h0);
    #1;
    chk("ra_idle_ready1", 32'(req1_if.ready), 32'h1);
    @(negedge clk);
    req1_if.valid = 1'b0;
    #1;
    chk("ra_readback_mem_read", 32'(mem_read), 32'h1);
    @(negedge clk);
    #1;
    chk("ra_readback_rvalid1", 32'(req1_if.rvalid), 32'h1);
    chk("ra_readback_rvalid0", 32'(req0_if.rvalid), 32'h0);
    chk("ra_readback_rdata1", req1_if.rdata, 32'h0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
